// File: rtl/count_uart_pkg.sv
// Shared types and constants for the counter UART serializer.
package count_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int FRAME_BITS = 10;

  // A width of zero is never allowed, even for the smallest bit period.
  function automatic int timer_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/count_uart_tx_if.sv
// Byte-wide valid/ready handshake carrying the counter value into the serializer.
interface count_uart_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: bit_done_o pulses on the last cycle of each bit, then reloads.
module uart_bit_timer
  import count_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic bit_done_o
);

  localparam int TW = timer_width(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d      = cnt_q - 1'b1;
    bit_done_o = (cnt_q == '0) && !restart_i;
    if (restart_i || (cnt_q == '0)) begin
      cnt_d = LAST;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= LAST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/count_uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register for gapless back-to-back frames.
module count_uart_tx
  import count_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  count_uart_tx_if.slave      in_if,
  output logic                tx,
  output logic                busy,
  output logic [7:0]          sent_cnt
);

  if (DATA_W != 8) begin : g_bad_data_w
    $error("count_uart_tx: DATA_W must be 8");
  end
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
    $error("count_uart_tx: CLKS_PER_BIT out of range 2..65535");
  end

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] idx_nxt;
  logic       tx_q, tx_d;
  logic [7:0] sent_q, sent_d;
  logic       bit_done;
  logic       accept;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (state_q == IDLE),
    .bit_done_o(bit_done)
  );

  // Ready never depends on in_valid, so upstream may gate valid on ready freely.
  assign in_if.in_ready = rst_n & ena & ~hold_full_q;
  assign accept         = in_if.in_valid & in_if.in_ready;
  assign idx_nxt        = idx_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    tx_d        = tx_q;
    sent_d      = sent_q;

    if (accept) begin
      hold_d      = in_if.in_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          tx_d        = 1'b0;
          state_d     = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_nxt;
            tx_d  = shift_q[idx_nxt];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          sent_d = sent_q + 8'd1;
          // A pending byte starts its start bit on the very next cycle.
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            tx_d        = 1'b0;
            state_d     = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      idx_q       <= 3'd0;
      tx_q        <= 1'b1;
      sent_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      tx_q        <= tx_d;
      sent_q      <= sent_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign sent_cnt = sent_q;

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed bench for count_uart_tx at 4 clocks per bit.
module tb_count_uart_tx;
  import count_uart_pkg::*;

  localparam int CPB = 4;
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       tx;
  logic       busy;
  logic [7:0] sent_cnt;

  count_uart_tx_if u_if ();

  count_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .in_if   (u_if),
    .tx      (tx),
    .busy    (busy),
    .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [FRAME_CYC-1:0] txv;
  logic [FRAME_CYC-1:0] rdyv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Record tx and in_ready for frame cycles [from..to], one sample per clock.
  task automatic grab(input int from, input int to);
    for (int k = from; k <= to; k++) begin
      txv[k]  = tx;
      rdyv[k] = u_if.in_ready;
      cyc();
    end
  endtask

  task automatic check_frame(input logic [7:0] b, input string tag);
    logic [FRAME_CYC-1:0] e;
    for (int k = 0; k < FRAME_CYC; k++) begin
      if (k < CPB) e[k] = 1'b0;
      else if (k >= 9 * CPB) e[k] = 1'b1;
      else e[k] = b[k / CPB - 1];
    end
    chk(tag, 64'(txv), 64'(e));
  endtask

  task automatic do_reset(input string tag);
    rst_n         = 1'b0;
    ena           = 1'b1;
    u_if.in_valid = 1'b0;
    #1;
    chk({tag, "_rdy_in_rst"}, u_if.in_ready, 1'b0);
    cyc();
    cyc();
    chk({tag, "_tx"}, tx, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_sent"}, sent_cnt, 8'd0);
    rst_n = 1'b1;
    #1;
    chk({tag, "_rdy_after"}, u_if.in_ready, 1'b1);
  endtask

  // Handshake from IDLE; returns positioned on the first start-bit cycle.
  task automatic hs(input logic [7:0] b, input string tag);
    u_if.in_data  = b;
    u_if.in_valid = 1'b1;
    #1;
    chk({tag, "_rdy_e0"}, u_if.in_ready, 1'b1);
    cyc();
    u_if.in_valid = 1'b0;
    chk({tag, "_held"}, u_if.in_ready, 1'b0);
    chk({tag, "_tx_e0"}, tx, 1'b1);
    cyc();
    chk({tag, "_tx_e1"}, tx, 1'b0);
    chk({tag, "_busy_e1"}, busy, 1'b1);
    chk({tag, "_rdy_e1"}, u_if.in_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    u_if.in_data  = 8'h00;
    u_if.in_valid = 1'b0;

    // Single byte 0xA5 (wire order 0,1,0,1,0,0,1,0,1,1)
    do_reset("rst0");
    hs(8'hA5, "s1");
    grab(0, FRAME_CYC - 1);
    check_frame(8'hA5, "s1_frame");
    chk("s1_sent", sent_cnt, 8'd1);
    chk("s1_busy", busy, 1'b0);
    chk("s1_tx_idle", tx, 1'b1);

    // 0x00 then 0xFF pushed during the first frame, zero gap between frames
    do_reset("rst1");
    hs(8'h00, "s2");
    u_if.in_data  = 8'hFF;
    u_if.in_valid = 1'b1;
    grab(0, 0);
    u_if.in_valid = 1'b0;
    grab(1, FRAME_CYC - 1);
    check_frame(8'h00, "s2_frame0");
    chk("s2_rdy_frame0", 64'(rdyv), 64'h1);
    chk("s2_busy_gap", busy, 1'b1);
    grab(0, FRAME_CYC - 1);
    check_frame(8'hFF, "s2_frame1");
    chk("s2_rdy_frame1", 64'(rdyv), {24'h0, {FRAME_CYC{1'b1}}});
    chk("s2_sent", sent_cnt, 8'd2);
    chk("s2_busy", busy, 1'b0);

    // Reset during data bit 3 of 0x3C, then a clean 0x81
    do_reset("rst2");
    hs(8'h3C, "s3");
    grab(0, 4 * CPB);
    chk("s3_bit3", tx, 1'b1);
    chk("s3_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("s3_rdy_in_rst", u_if.in_ready, 1'b0);
    cyc();
    chk("s3_tx_rst", tx, 1'b1);
    chk("s3_busy_rst", busy, 1'b0);
    chk("s3_sent_rst", sent_cnt, 8'd0);
    chk("s3_rdy_rst", u_if.in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("s3_rdy_rel", u_if.in_ready, 1'b1);
    hs(8'h81, "s3b");
    grab(0, FRAME_CYC - 1);
    check_frame(8'h81, "s3_frame");
    chk("s3_sent", sent_cnt, 8'd1);

    // ena dropped at START of 0x55 with 0x99 held; 0x77 offered while disabled
    do_reset("rst3");
    hs(8'h55, "s4");
    u_if.in_data  = 8'h99;
    u_if.in_valid = 1'b1;
    grab(0, 0);
    ena          = 1'b0;
    u_if.in_data = 8'h77;
    grab(1, FRAME_CYC - 1);
    check_frame(8'h55, "s4_frame0");
    chk("s4_rdy_frame0", 64'(rdyv), 64'h1);
    grab(0, FRAME_CYC - 1);
    check_frame(8'h99, "s4_frame1");
    chk("s4_rdy_frame1", 64'(rdyv), 64'h0);
    chk("s4_sent", sent_cnt, 8'd2);
    chk("s4_busy", busy, 1'b0);
    cyc();
    cyc();
    cyc();
    chk("s4_no_accept_busy", busy, 1'b0);
    chk("s4_no_accept_tx", tx, 1'b1);
    chk("s4_rdy_dis", u_if.in_ready, 1'b0);
    u_if.in_valid = 1'b0;
    ena           = 1'b1;
    #1;
    chk("s4_rdy_en", u_if.in_ready, 1'b1);

    // 256 back-to-back frames 0x00..0xFF, sent_cnt wraps
    do_reset("rst4");
    hs(8'h00, "s5");
    for (int i = 0; i < 256; i++) begin
      if (i < 255) begin
        u_if.in_data  = 8'(i + 1);
        u_if.in_valid = 1'b1;
      end
      grab(0, 0);
      u_if.in_valid = 1'b0;
      grab(1, FRAME_CYC - 1);
      check_frame(8'(i), $sformatf("s5_frame_%0d", i));
      chk($sformatf("s5_sent_%0d", i), sent_cnt, 64'((i + 1) % 256));
    end
    chk("s5_busy_end", busy, 1'b0);
    chk("s5_sent_wrap", sent_cnt, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
